// File: rtl/vga_pkg.sv
// Timing defaults, object record type and RGB packing positions shared by the VGA object renderer.
package vga_pkg;

    localparam int H_ACTIVE_DEF = 640;
    localparam int H_FP_DEF     = 16;
    localparam int H_SYNC_DEF   = 96;
    localparam int H_BP_DEF     = 48;
    localparam int V_ACTIVE_DEF = 480;
    localparam int V_FP_DEF     = 10;
    localparam int V_SYNC_DEF   = 2;
    localparam int V_BP_DEF     = 33;

    localparam int NUM_OBJS_DEF  = 16;
    localparam int CELL_LOG2_DEF = 5;
    localparam int COL_W_DEF     = 5;
    localparam int ROW_W_DEF     = 4;
    localparam int CW_DEF        = 3;

    // Channel slot within a packed {r,g,b} word: channel c lives at [c*CW +: CW].
    localparam int R_SLOT = 2;
    localparam int G_SLOT = 1;
    localparam int B_SLOT = 0;

    typedef struct packed {
        logic                   vis;
        logic [COL_W_DEF-1:0]   col;
        logic [ROW_W_DEF-1:0]   row;
        logic [3*CW_DEF-1:0]    rgb;
    } obj_t;

endpackage

// File: rtl/vga_timing_gen.sv
// Purpose: free-running VGA pixel/line counters with raw sync, active-video and frame/blank strobes.
// Latency: flags are combinational from the counters, which advance every clk.
// Backpressure: none; runs continuously out of reset.
module vga_timing_gen
    import vga_pkg::*;
#(
    parameter int H_ACTIVE = H_ACTIVE_DEF,
    parameter int H_FP     = H_FP_DEF,
    parameter int H_SYNC   = H_SYNC_DEF,
    parameter int H_BP     = H_BP_DEF,
    parameter int V_ACTIVE = V_ACTIVE_DEF,
    parameter int V_FP     = V_FP_DEF,
    parameter int V_SYNC   = V_SYNC_DEF,
    parameter int V_BP     = V_BP_DEF,
    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP,
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP,
    localparam int HW      = $clog2(H_TOTAL),
    localparam int VW      = $clog2(V_TOTAL)
) (
    input  logic          clk,
    input  logic          rst_n,
    output logic [HW-1:0] h_cnt,
    output logic [VW-1:0] v_cnt,
    output logic          hs_raw,
    output logic          vs_raw,
    output logic          de_raw,
    output logic          frame_stb,
    output logic          blank_stb
);

    localparam logic [HW-1:0] H_LAST = HW'(H_TOTAL - 1);
    localparam logic [VW-1:0] V_LAST = VW'(V_TOTAL - 1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            h_cnt <= '0;
            v_cnt <= '0;
        end else if (h_cnt == H_LAST) begin
            h_cnt <= '0;
            v_cnt <= (v_cnt == V_LAST) ? '0 : v_cnt + 1'b1;
        end else begin
            h_cnt <= h_cnt + 1'b1;
        end
    end

    assign de_raw    = (h_cnt < HW'(H_ACTIVE)) && (v_cnt < VW'(V_ACTIVE));
    assign hs_raw    = !((h_cnt >= HW'(H_ACTIVE + H_FP)) && (h_cnt < HW'(H_ACTIVE + H_FP + H_SYNC)));
    assign vs_raw    = !((v_cnt >= VW'(V_ACTIVE + V_FP)) && (v_cnt < VW'(V_ACTIVE + V_FP + V_SYNC)));
    assign frame_stb = (h_cnt == '0) && (v_cnt == '0);
    assign blank_stb = (h_cnt == '0) && (v_cnt == VW'(V_ACTIVE));

endmodule

// File: rtl/vga_object_renderer.sv
// Purpose: VGA raster of a cell grid where the lowest-indexed visible object on a cell paints it, else bg_rgb.
// Latency: colour, syncs, de and frame_start all lag the counters by 2 clk.
// Backpressure: obj_wr_ready low outside vertical blanking; always high with VGA_DOUBLE_BUFFER_EN (shadow table).
module vga_object_renderer
    import vga_pkg::*;
#(
    parameter int NUM_OBJS  = NUM_OBJS_DEF,
    parameter int CELL_LOG2 = CELL_LOG2_DEF,
    parameter int COL_W     = COL_W_DEF,
    parameter int ROW_W     = ROW_W_DEF,
    parameter int CW        = CW_DEF,
    parameter int H_ACTIVE  = H_ACTIVE_DEF,
    parameter int H_FP      = H_FP_DEF,
    parameter int H_SYNC    = H_SYNC_DEF,
    parameter int H_BP      = H_BP_DEF,
    parameter int V_ACTIVE  = V_ACTIVE_DEF,
    parameter int V_FP      = V_FP_DEF,
    parameter int V_SYNC    = V_SYNC_DEF,
    parameter int V_BP      = V_BP_DEF,
    localparam int IW       = $clog2(NUM_OBJS),
    localparam int HW       = $clog2(H_ACTIVE + H_FP + H_SYNC + H_BP),
    localparam int VW       = $clog2(V_ACTIVE + V_FP + V_SYNC + V_BP)
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            obj_wr_valid,
    output logic            obj_wr_ready,
    input  logic [IW-1:0]   obj_wr_idx,
    input  logic [COL_W-1:0] obj_wr_col,
    input  logic [ROW_W-1:0] obj_wr_row,
    input  logic            obj_wr_vis,
    input  logic [3*CW-1:0] obj_wr_rgb,
    input  logic [3*CW-1:0] bg_rgb,
    output logic [CW-1:0]   vga_r,
    output logic [CW-1:0]   vga_g,
    output logic [CW-1:0]   vga_b,
    output logic            vga_hs,
    output logic            vga_vs,
    output logic            vga_de,
    output logic            frame_start
);

    typedef struct packed {
        logic             vis;
        logic [COL_W-1:0] col;
        logic [ROW_W-1:0] row;
        logic [3*CW-1:0]  rgb;
    } slot_t;

    logic [HW-1:0] h_cnt;
    logic [VW-1:0] v_cnt;
    logic          hs_raw, vs_raw, de_raw, frame_stb, blank_stb;

    vga_timing_gen #(
        .H_ACTIVE (H_ACTIVE), .H_FP (H_FP), .H_SYNC (H_SYNC), .H_BP (H_BP),
        .V_ACTIVE (V_ACTIVE), .V_FP (V_FP), .V_SYNC (V_SYNC), .V_BP (V_BP)
    ) u_timing (
        .clk       (clk),
        .rst_n     (rst_n),
        .h_cnt     (h_cnt),
        .v_cnt     (v_cnt),
        .hs_raw    (hs_raw),
        .vs_raw    (vs_raw),
        .de_raw    (de_raw),
        .frame_stb (frame_stb),
        .blank_stb (blank_stb)
    );

    slot_t act_tbl [NUM_OBJS];
    slot_t wr_slot;
    logic  wr_hit;

    assign wr_slot = '{vis: obj_wr_vis, col: obj_wr_col, row: obj_wr_row, rgb: obj_wr_rgb};
    // Out-of-range indices still handshake but land nowhere.
    assign wr_hit  = obj_wr_valid && obj_wr_ready && (int'(obj_wr_idx) < NUM_OBJS);

`ifdef VGA_DOUBLE_BUFFER_EN
    slot_t shd_tbl [NUM_OBJS];

    assign obj_wr_ready = 1'b1;

    // The swap copies the shadow with this cycle's write already merged in.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_OBJS; i++) begin
                shd_tbl[i] <= '0;
                act_tbl[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NUM_OBJS; i++) begin
                if (blank_stb)
                    act_tbl[i] <= (wr_hit && int'(obj_wr_idx) == i) ? wr_slot : shd_tbl[i];
            end
            if (wr_hit)
                shd_tbl[obj_wr_idx] <= wr_slot;
        end
    end
`else
    logic vblank_q;

    // vblank_q spans the lines after the blank strobe up to, not including, the next frame's first pixel.
    assign obj_wr_ready = blank_stb || (vblank_q && !frame_stb);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vblank_q <= 1'b0;
            for (int i = 0; i < NUM_OBJS; i++)
                act_tbl[i] <= '0;
        end else begin
            if (blank_stb)
                vblank_q <= 1'b1;
            else if (frame_stb)
                vblank_q <= 1'b0;
            if (wr_hit)
                act_tbl[obj_wr_idx] <= wr_slot;
        end
    end
`endif

    logic [COL_W-1:0] s1_col;
    logic [ROW_W-1:0] s1_row;
    logic             s1_hs, s1_vs, s1_de, s1_fs;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_col <= '0;
            s1_row <= '0;
            s1_hs  <= 1'b1;
            s1_vs  <= 1'b1;
            s1_de  <= 1'b0;
            s1_fs  <= 1'b0;
        end else begin
            s1_col <= COL_W'(h_cnt >> CELL_LOG2);
            s1_row <= ROW_W'(v_cnt >> CELL_LOG2);
            s1_hs  <= hs_raw;
            s1_vs  <= vs_raw;
            s1_de  <= de_raw;
            s1_fs  <= frame_stb;
        end
    end

    logic [3*CW-1:0] pix_rgb;

    // Walk from the top slot down so the lowest matching index wins.
    always_comb begin
        pix_rgb = bg_rgb;
        for (int i = NUM_OBJS - 1; i >= 0; i--) begin
            if (act_tbl[i].vis && act_tbl[i].col == s1_col && act_tbl[i].row == s1_row)
                pix_rgb = act_tbl[i].rgb;
        end
    end

    logic [3*CW-1:0] rgb_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rgb_q       <= '0;
            vga_hs      <= 1'b1;
            vga_vs      <= 1'b1;
            vga_de      <= 1'b0;
            frame_start <= 1'b0;
        end else begin
            rgb_q       <= s1_de ? pix_rgb : '0;
            vga_hs      <= s1_hs;
            vga_vs      <= s1_vs;
            vga_de      <= s1_de;
            frame_start <= s1_fs;
        end
    end

    assign vga_r = rgb_q[R_SLOT*CW +: CW];
    assign vga_g = rgb_q[G_SLOT*CW +: CW];
    assign vga_b = rgb_q[B_SLOT*CW +: CW];

endmodule

// File: tb/tb_vga_object_renderer.sv
// Bench for vga_object_renderer on a shrunken raster (40x30 totals, 4-pixel cells), checked every cycle
// against a frame-position reference model; builds with or without VGA_DOUBLE_BUFFER_EN.
module tb_vga_object_renderer;
    import vga_pkg::*;

    localparam int HA = 32, HFP = 2, HSY = 4, HBP = 2, HT = HA + HFP + HSY + HBP;
    localparam int VA = 24, VFP = 2, VSY = 2, VBP = 2, VT = VA + VFP + VSY + VBP;
    localparam int FT = HT * VT;
    localparam int NOBJ = 12, CL = 2, CELL = 1 << CL;
    localparam logic [8:0] BG = 9'o123;
`ifdef VGA_DOUBLE_BUFFER_EN
    localparam int NEED = 2;
`else
    localparam int NEED = 1;
`endif

    logic       clk = 1'b0;
    logic       rst_n;
    logic       wr_valid, wr_ready, wr_vis;
    logic [3:0] wr_idx;
    logic [4:0] wr_col;
    logic [3:0] wr_row;
    logic [8:0] wr_rgb, bg;
    logic [2:0] vga_r, vga_g, vga_b;
    logic       vga_hs, vga_vs, vga_de, frame_start;

    always #5 clk = ~clk;

    vga_object_renderer #(
        .NUM_OBJS (NOBJ), .CELL_LOG2 (CL), .COL_W (5), .ROW_W (4), .CW (3),
        .H_ACTIVE (HA), .H_FP (HFP), .H_SYNC (HSY), .H_BP (HBP),
        .V_ACTIVE (VA), .V_FP (VFP), .V_SYNC (VSY), .V_BP (VBP)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .obj_wr_valid (wr_valid),
        .obj_wr_ready (wr_ready),
        .obj_wr_idx   (wr_idx),
        .obj_wr_col   (wr_col),
        .obj_wr_row   (wr_row),
        .obj_wr_vis   (wr_vis),
        .obj_wr_rgb   (wr_rgb),
        .bg_rgb       (bg),
        .vga_r        (vga_r),
        .vga_g        (vga_g),
        .vga_b        (vga_b),
        .vga_hs       (vga_hs),
        .vga_vs       (vga_vs),
        .vga_de       (vga_de),
        .frame_start  (frame_start)
    );

    int checks = 0, errors = 0;
    int k;
    logic acc;
    obj_t act_m [NOBJ];
    obj_t shd_m [NOBJ];

    logic       probe_on;
    int         probe_x, probe_y, probe_frames, probe_need;
    logic [8:0] probe_exp;

    typedef struct {
        logic [3:0] idx;
        logic [4:0] col;
        logic [3:0] row;
        logic       vis;
        logic [8:0] rgb;
        int         px;
        int         py;
        logic [8:0] exp_rgb;
    } vec_t;
    vec_t vt [9];

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, k);
        end
    endtask

    task automatic clear_model();
        for (int i = 0; i < NOBJ; i++) begin
            act_m[i] = '0;
            shd_m[i] = '0;
        end
    endtask

    function automatic logic [8:0] model_rgb(input int x, input int y);
        for (int i = 0; i < NOBJ; i++)
            if (act_m[i].vis && int'(act_m[i].col) == x / CELL && int'(act_m[i].row) == y / CELL)
                return act_m[i].rgb;
        return BG;
    endfunction

    // Expected output word {rgb, hs, vs, de, frame_start} for the pixel counted at cycle p.
    task automatic check_pixel(input int p);
        logic [12:0] exp;
        int q, x, y;
        logic de, hs, vs;
        if (p < 0) begin
            exp = {9'd0, 1'b1, 1'b1, 1'b0, 1'b0};
        end else begin
            q  = p % FT;
            x  = q % HT;
            y  = q / HT;
            de = (x < HA) && (y < VA);
            hs = !(x >= HA + HFP && x < HA + HFP + HSY);
            vs = !(y >= VA + VFP && y < VA + VFP + VSY);
            exp = {de ? model_rgb(x, y) : 9'd0, hs, vs, de, q == 0};
            if (probe_on && q == 0)
                probe_frames++;
            if (probe_on && probe_frames >= probe_need && x == probe_x && y == probe_y) begin
                check("probe_rgb", {7'd0, vga_r, vga_g, vga_b}, {7'd0, probe_exp});
                probe_on = 1'b0;
            end
        end
        check("pixel", {3'd0, vga_r, vga_g, vga_b, vga_hs, vga_vs, vga_de, frame_start}, {3'd0, exp});
    endtask

    task automatic step();
        int pos;
        logic exp_rdy;
        pos = k % FT;
`ifdef VGA_DOUBLE_BUFFER_EN
        exp_rdy = 1'b1;
`else
        exp_rdy = (pos / HT) >= VA;
`endif
        check("wr_ready", {15'd0, wr_ready}, {15'd0, exp_rdy});
        acc = wr_valid && exp_rdy;
        if (acc && int'(wr_idx) < NOBJ) begin
`ifdef VGA_DOUBLE_BUFFER_EN
            shd_m[wr_idx] = '{vis: wr_vis, col: wr_col, row: wr_row, rgb: wr_rgb};
`else
            act_m[wr_idx] = '{vis: wr_vis, col: wr_col, row: wr_row, rgb: wr_rgb};
`endif
        end
`ifdef VGA_DOUBLE_BUFFER_EN
        if (pos == VA * HT)
            act_m = shd_m;
`endif
        @(posedge clk);
        k++;
        @(negedge clk);
        check_pixel(k - 2);
    endtask

    task automatic run_to(input int target);
        for (int n = 0; n < 2 * FT && (k % FT) != target; n++)
            step();
    endtask

    task automatic set_write(input logic [3:0] idx, input logic [4:0] col, input logic [3:0] row,
                             input logic vis, input logic [8:0] rgb);
        wr_valid = 1'b1;
        wr_idx   = idx;
        wr_col   = col;
        wr_row   = row;
        wr_vis   = vis;
        wr_rgb   = rgb;
    endtask

    task automatic probe(input int px, input int py, input logic [8:0] exp, input int need);
        probe_x = px; probe_y = py; probe_exp = exp;
        probe_need = need; probe_frames = 0; probe_on = 1'b1;
        for (int n = 0; n < 4 * FT && probe_on; n++)
            step();
        if (probe_on) begin
            checks++;
            errors++;
            $display("FAIL probe_timeout: pixel (%0d,%0d) never observed, required %0h", px, py, exp);
            probe_on = 1'b0;
        end
    endtask

    task automatic check_reset_outputs(input string name);
        check(name, {3'd0, vga_r, vga_g, vga_b, vga_hs, vga_vs, vga_de, frame_start},
              {3'd0, 9'd0, 1'b1, 1'b1, 1'b0, 1'b0});
`ifdef VGA_DOUBLE_BUFFER_EN
        check({name, "_ready"}, {15'd0, wr_ready}, 16'd1);
`else
        check({name, "_ready"}, {15'd0, wr_ready}, 16'd0);
`endif
    endtask

    initial begin
        #(200000 * 10);
        $display("FAIL watchdog: simulation did not finish, required completion");
        $fatal(1, "watchdog");
    end

    initial begin
        vt[0] = '{4'd3,  5'd2, 4'd1, 1'b1, 9'o700, 9,  5,  9'o700};
        vt[1] = '{4'd3,  5'd2, 4'd1, 1'b1, 9'o700, 12, 5,  BG};
        vt[2] = '{4'd1,  5'd4, 4'd2, 1'b1, 9'o070, 17, 9,  9'o070};
        vt[3] = '{4'd5,  5'd4, 4'd2, 1'b1, 9'o007, 17, 9,  9'o070};
        vt[4] = '{4'd1,  5'd4, 4'd2, 1'b0, 9'o070, 17, 9,  9'o007};
        vt[5] = '{4'd13, 5'd0, 4'd0, 1'b1, 9'o777, 0,  0,  BG};
        vt[6] = '{4'd0,  5'd7, 4'd5, 1'b1, 9'o456, 31, 23, 9'o456};
        vt[7] = '{4'd11, 5'd0, 4'd0, 1'b1, 9'o321, 0,  0,  9'o321};
        vt[8] = '{4'd11, 5'd0, 4'd0, 1'b0, 9'o321, 3,  3,  BG};

        rst_n = 1'b0; wr_valid = 1'b0; wr_idx = '0; wr_col = '0; wr_row = '0;
        wr_vis = 1'b0; wr_rgb = '0; bg = BG; k = 0; acc = 1'b0; probe_on = 1'b0;
        clear_model();
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_reset_outputs("reset_state");
        rst_n = 1'b1;

        // Idle frame: sync widths, de window and background everywhere.
        repeat (FT + 4) step();

        foreach (vt[i]) begin
            run_to((VA + 1) * HT);
            set_write(vt[i].idx, vt[i].col, vt[i].row, vt[i].vis, vt[i].rgb);
            step();
            wr_valid = 1'b0;
            probe(vt[i].px, vt[i].py, vt[i].exp_rgb, NEED);
        end

        // Back-to-back writes to one slot: the later one must stick.
        run_to((VA + 1) * HT);
        set_write(4'd3, 5'd2, 4'd1, 1'b1, 9'o555);
        step();
        set_write(4'd3, 5'd2, 4'd1, 1'b1, 9'o111);
        step();
        wr_valid = 1'b0;
        probe(9, 5, 9'o111, NEED);

        // Valid raised mid-frame and held until the handshake completes.
        run_to(2 * HT + 5);
        set_write(4'd6, 5'd1, 4'd1, 1'b1, 9'o246);
        for (int n = 0; n < 2 * FT; n++) begin
            step();
            if (acc) break;
        end
        wr_valid = 1'b0;
        probe(5, 5, 9'o246, 1);

        // Random writes anywhere in the frame, including out-of-range slots.
        for (int n = 0; n < 3 * FT; n++) begin
            if (!wr_valid && $urandom_range(0, 7) == 0)
                set_write(4'($urandom_range(0, 15)), 5'($urandom_range(0, 7)), 4'($urandom_range(0, 5)),
                          1'($urandom_range(0, 1)), 9'($urandom_range(0, 511)));
            step();
            if (acc) wr_valid = 1'b0;
        end
        for (int n = 0; n < 2 * FT && wr_valid; n++) begin
            step();
            if (acc) wr_valid = 1'b0;
        end
        repeat (2 * FT) step();

        // Mid-line reset with a write pending: outputs drop at once, table and frame are discarded.
        run_to(3 * HT + 10);
        set_write(4'd2, 5'd0, 4'd0, 1'b1, 9'o777);
        rst_n = 1'b0;
        #1;
        check_reset_outputs("midline_reset");
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_reset_outputs("held_reset");
        wr_valid = 1'b0;
        clear_model();
        k = 0;
        rst_n = 1'b1;
        repeat (FT + 4) step();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
